// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and the byte-to-word address helper for the memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {RESP_NONE, RESP_IFETCH, RESP_DREAD} resp_src_e;

    // Callers truncate the result to their own word-address width.
    function automatic logic [63:0] word_addr(input logic [63:0] byte_addr);
        return byte_addr >> 2;
    endfunction

endpackage

// File: rtl/mem_arb_fairness.sv
// mem_arb_fairness: counts consecutive data grants while a fetch waits and forces a fetch grant at the limit.
module mem_arb_fairness #(
    parameter int MAX_STREAK = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_req,
    input  logic d_gnt,
    input  logic i_gnt,
    output logic force_ifetch
);

    localparam int SW = $clog2(MAX_STREAK + 1);

    logic [SW-1:0] streak_q, streak_d;

    assign force_ifetch = streak_q == SW'(MAX_STREAK);

    always_comb
        streak_d = (!i_req || i_gnt) ? '0 : (d_gnt && !force_ifetch) ? streak_q + 1'b1 : streak_q;

    always_ff @(posedge clk or negedge reset)
        if (!reset) streak_q <= '0;
        else        streak_q <= streak_d;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous-read memory between fetch and data ports,
// data first, with fetch starvation bounded by mem_arb_fairness.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MW         = 6,
    parameter int MAX_STREAK = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [MW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    resp_src_e resp_src_q, resp_src_d;
    logic      force_ifetch;

    mem_arb_fairness #(.MAX_STREAK(MAX_STREAK)) u_fairness (
        .clk          (clk),
        .reset        (reset),
        .i_req        (i_req),
        .d_gnt        (d_gnt),
        .i_gnt        (i_gnt),
        .force_ifetch (force_ifetch)
    );

    // force_ifetch can only be set while a fetch has been waiting, so a lone data request always wins.
    always_comb begin
        i_gnt      = reset && i_req && (!d_req || force_ifetch);
        d_gnt      = reset && d_req && (!i_req || !force_ifetch);
        mem_en     = i_gnt || d_gnt;
        mem_we     = d_gnt && d_we;
        mem_addr   = MW'(word_addr(64'(i_gnt ? i_addr : d_addr)));
        mem_wdata  = d_gnt ? d_wdata : '0;
        resp_src_d = i_gnt ? RESP_IFETCH : (d_gnt && !d_we) ? RESP_DREAD : RESP_NONE;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) resp_src_q <= RESP_NONE;
        else        resp_src_q <= resp_src_d;

    assign i_rvalid = resp_src_q == RESP_IFETCH;
    assign d_rvalid = resp_src_q == RESP_DREAD;
    assign i_rdata  = mem_rdata;
    assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic checked against a
// queue/array reference model of the arbitration and memory rules.
module tb_mem_arbiter;

    localparam int AW = 32, DW = 32, MW = 6, MS = 4;

    logic          clk = 0, reset = 0;
    logic          i_req = 0, d_req = 0, d_we = 0;
    logic [AW-1:0] i_addr = 0, d_addr = 0;
    logic [DW-1:0] d_wdata = 0;
    logic          i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
    logic [DW-1:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
    logic [MW-1:0] mem_addr;

    logic [DW-1:0] mem [64];
    logic [DW-1:0] ref_mem [64];
    int n_cmp = 0, n_err = 0;
    logic pi = 0, pd = 0;

    mem_arbiter #(.AW(AW), .DW(DW), .MW(MW), .MAX_STREAK(MS)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM model.
    always @(posedge clk)
        if (mem_en) begin
            if (mem_we) mem[mem_addr] = mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end

    // Requests must be held until granted.
    always @(posedge clk) begin
        pi <= reset & i_req & ~i_gnt;
        pd <= reset & d_req & ~d_gnt;
    end
    always @(negedge clk)
        if (reset && ((pi && !i_req) || (pd && !d_req))) begin
            n_err++;
            $display("FAIL protocol: request dropped before grant i=%0b d=%0b", pi && !i_req, pd && !d_req);
        end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        i_req = 1; d_req = 1;
        @(negedge clk);
        n_cmp++;
        if ({i_gnt, d_gnt, mem_en, mem_we, i_rvalid, d_rvalid} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {i_gnt, d_gnt, mem_en, mem_we, i_rvalid, d_rvalid});
        end
        next_cycle();
        reset = 1; i_req = 0; d_req = 0;
        @(negedge clk);
        n_cmp++;
        if ({i_rvalid, d_rvalid} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_release_rvalid: got %b expected 00", {i_rvalid, d_rvalid});
        end
        next_cycle();
    endtask

    task automatic test_fetch();
        logic [DW-1:0] exp_d [3] = '{32'h11, 32'h22, 32'h33};
        for (int k = 0; k < 4; k++) begin
            i_req = k < 3; i_addr = 32'(k * 4);
            @(negedge clk);
            if (k < 3) begin
                n_cmp++;
                if ({i_gnt, mem_en, mem_we, mem_addr} !== {3'b110, 6'(k)}) begin
                    n_err++;
                    $display("FAIL fetch_grant[%0d]: got %b expected %b", k,
                             {i_gnt, mem_en, mem_we, mem_addr}, {3'b110, 6'(k)});
                end
            end
            n_cmp++;
            if (k == 0 ? i_rvalid !== 1'b0 : {i_rvalid, i_rdata} !== {1'b1, exp_d[k-1]}) begin
                n_err++;
                $display("FAIL fetch_resp[%0d]: got rvalid=%b data=%h", k, i_rvalid, i_rdata);
            end
            next_cycle();
        end
    endtask

    task automatic test_write_read();
        d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
        @(negedge clk);
        n_cmp++;
        if ({d_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, 6'd16, 32'hDEADBEEF}) begin
            n_err++;
            $display("FAIL wr_drive: got gnt=%b en=%b we=%b addr=%0d wdata=%h expected 1 1 1 16 deadbeef",
                     d_gnt, mem_en, mem_we, mem_addr, mem_wdata);
        end
        next_cycle();
        d_we = 0;
        @(negedge clk);
        n_cmp++;
        if ({d_gnt, mem_we, mem_addr, d_rvalid, i_rvalid} !== {2'b10, 6'd16, 2'b00}) begin
            n_err++;
            $display("FAIL rd_drive: got gnt=%b we=%b addr=%0d drv=%b irv=%b expected 1 0 16 0 0",
                     d_gnt, mem_we, mem_addr, d_rvalid, i_rvalid);
        end
        next_cycle();
        d_req = 0;
        @(negedge clk);
        n_cmp++;
        if ({d_rvalid, i_rvalid, d_rdata} !== {2'b10, 32'hDEADBEEF}) begin
            n_err++;
            $display("FAIL rd_resp: got drv=%b irv=%b data=%h expected 1 0 deadbeef",
                     d_rvalid, i_rvalid, d_rdata);
        end
        next_cycle();
    endtask

    task automatic test_contention();
        i_req = 1; d_req = 1; d_we = 0; i_addr = 0; d_addr = 32'h40;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({i_gnt, d_gnt} !== ((k % 5 == 4) ? 2'b10 : 2'b01)) begin
                n_err++;
                $display("FAIL contention[%0d]: got i_gnt,d_gnt=%b expected %b", k, {i_gnt, d_gnt},
                         (k % 5 == 4) ? 2'b10 : 2'b01);
            end
            next_cycle();
        end
        i_req = 0;
        @(negedge clk);
        n_cmp++;
        if ({i_gnt, d_gnt} !== 2'b01) begin
            n_err++;
            $display("FAIL contention_tail: got %b expected 01", {i_gnt, d_gnt});
        end
        next_cycle();
        d_req = 0;
        next_cycle();
    endtask

    task automatic test_overlap();
        i_req = 1; i_addr = 0;
        next_cycle();
        i_req = 0; d_req = 1; d_we = 0; d_addr = 32'h40;
        @(negedge clk);
        n_cmp++;
        if ({d_gnt, i_rvalid, d_rvalid, i_rdata} !== {3'b110, 32'h11}) begin
            n_err++;
            $display("FAIL overlap_n1: got gnt=%b irv=%b drv=%b data=%h expected 1 1 0 00000011",
                     d_gnt, i_rvalid, d_rvalid, i_rdata);
        end
        next_cycle();
        d_req = 0;
        @(negedge clk);
        n_cmp++;
        if ({i_rvalid, d_rvalid, d_rdata} !== {2'b01, 32'hDEADBEEF}) begin
            n_err++;
            $display("FAIL overlap_n2: got irv=%b drv=%b data=%h expected 0 1 deadbeef",
                     i_rvalid, d_rvalid, d_rdata);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_read();
        d_req = 1; d_we = 0; d_addr = 32'h40;
        next_cycle();
        d_req = 0; reset = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({d_rvalid, i_rvalid, d_gnt, mem_en} !== 4'b0) begin
                n_err++;
                $display("FAIL reset_mid[%0d]: got drv,irv,gnt,en=%b expected 0000", k,
                         {d_rvalid, i_rvalid, d_gnt, mem_en});
            end
            next_cycle();
        end
        reset = 1;
        @(negedge clk);
        n_cmp++;
        if ({d_rvalid, i_rvalid} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_mid_release: got %b expected 00", {d_rvalid, i_rvalid});
        end
        next_cycle();
        d_req = 1;
        @(negedge clk);
        n_cmp++;
        if ({d_gnt, mem_addr} !== {1'b1, 6'd16}) begin
            n_err++;
            $display("FAIL reset_mid_post_gnt: got gnt=%b addr=%0d expected 1 16", d_gnt, mem_addr);
        end
        next_cycle();
        d_req = 0;
        @(negedge clk);
        n_cmp++;
        if ({d_rvalid, d_rdata} !== {1'b1, 32'hDEADBEEF}) begin
            n_err++;
            $display("FAIL reset_mid_post_resp: got rv=%b data=%h expected 1 deadbeef", d_rvalid, d_rdata);
        end
        next_cycle();
    endtask

    task automatic test_misaligned();
        d_req = 1; d_we = 0; d_addr = 32'hFFFF_0107;
        @(negedge clk);
        n_cmp++;
        if ({d_gnt, mem_addr} !== {1'b1, 6'h01}) begin
            n_err++;
            $display("FAIL misaligned_addr: got gnt=%b addr=%h expected 1 01", d_gnt, mem_addr);
        end
        next_cycle();
        d_req = 0;
        @(negedge clk);
        n_cmp++;
        if ({d_rvalid, d_rdata} !== {1'b1, 32'h22}) begin
            n_err++;
            $display("FAIL misaligned_data: got rv=%b data=%h expected 1 00000022", d_rvalid, d_rdata);
        end
        next_cycle();
    endtask

    task automatic test_random();
        int streak = 0, wait_i = 0, max_wait = 0;
        bit exp_ig, exp_dg, exp_irv = 0, exp_drv = 0;
        logic [DW-1:0] exp_data = 0;
        for (int k = 0; k < 64; k++) ref_mem[k] = mem[k];
        for (int c = 0; c < 400; c++) begin
            if (!i_req && c < 380 && $urandom_range(0, 3) != 0) begin
                i_req = 1; i_addr = $urandom;
            end
            if (!d_req && c < 380 && $urandom_range(0, 4) != 0) begin
                d_req = 1; d_we = $urandom_range(0, 1); d_addr = $urandom; d_wdata = $urandom;
            end
            exp_dg = d_req && (!i_req || streak < MS);
            exp_ig = i_req && !exp_dg;
            @(negedge clk);
            n_cmp++;
            if ({i_gnt, d_gnt, mem_en, mem_we} !== {exp_ig, exp_dg, exp_ig | exp_dg, exp_dg & d_we}) begin
                n_err++;
                $display("FAIL rand_grant[%0d]: got ig,dg,en,we=%b expected %b", c,
                         {i_gnt, d_gnt, mem_en, mem_we}, {exp_ig, exp_dg, exp_ig | exp_dg, exp_dg & d_we});
            end
            n_cmp++;
            if ({i_rvalid, d_rvalid} !== {exp_irv, exp_drv} ||
                (exp_irv && i_rdata !== exp_data) || (exp_drv && d_rdata !== exp_data)) begin
                n_err++;
                $display("FAIL rand_resp[%0d]: got irv=%b drv=%b idata=%h ddata=%h expected %b %b %h", c,
                         i_rvalid, d_rvalid, i_rdata, d_rdata, exp_irv, exp_drv, exp_data);
            end
            exp_irv = exp_ig;
            exp_drv = exp_dg && !d_we;
            exp_data = exp_ig ? ref_mem[i_addr[7:2]] : ref_mem[d_addr[7:2]];
            if (exp_dg && d_we) ref_mem[d_addr[7:2]] = d_wdata;
            streak = (!i_req || exp_ig) ? 0 : (exp_dg ? (streak < MS ? streak + 1 : MS) : streak);
            wait_i = (i_req && !exp_ig) ? wait_i + 1 : 0;
            if (wait_i > max_wait) max_wait = wait_i;
            next_cycle();
            if (i_gnt_seen(exp_ig)) i_req = 0;
            if (exp_dg) d_req = 0;
        end
        n_cmp++;
        if (max_wait > MS) begin
            n_err++;
            $display("FAIL rand_starvation: fetch waited %0d cycles, limit %0d", max_wait, MS);
        end
    endtask

    function automatic bit i_gnt_seen(input bit g);
        return g;
    endfunction

    initial begin
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33;
        for (int k = 3; k < 64; k++) mem[k] = 32'(k * 32'h01010101);
        test_reset();
        test_fetch();
        test_write_read();
        test_contention();
        test_overlap();
        test_reset_mid_read();
        test_misaligned();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
